tour_len_ctrl: RTL and testbench

- Sequencer that computes the closed-tour length used by the simulated-annealing core.
- Walks a tour permutation stored in an external tour RAM and fetches each city's packed coordinates from a coordinate RAM.
- Streams consecutive city pairs, including the wrap-around pair, into the pipelined distance unit and accumulates the returned distances.
- Sits between the SA move/accept logic and the single distance datapath; it owns that datapath while busy.

---
 rtl/tsp_pkg.sv | 41 ++++
 rtl/tour_fetch_pipe.sv | 83 ++++++++
 rtl/tour_len_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_tour_len_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsp_pkg.sv
//------------------------------------------------------------------------------
// Module : tsp_pkg
// Brief  : Shared widths, coordinate packing helpers, tour_len_ctrl states.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tsp_pkg;

  localparam int CITY_W = 64;
  localparam int DIST_W = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CLOSE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_CLOSE = ST_CLOSE,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } tl_state_e;

  function automatic logic [CITY_W-1:0] pack_city(input logic [31:0] x, input logic [31:0] y);
    return {y, x};
  endfunction

  function automatic logic [31:0] city_x(input logic [CITY_W-1:0] c);
    return c[31:0];
  endfunction

  function automatic logic [31:0] city_y(input logic [CITY_W-1:0] c);
    return c[63:32];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tour_fetch_pipe.sv
//------------------------------------------------------------------------------
// Module : tour_fetch_pipe
// Brief  : Two-stage tour RAM -> coordinate RAM read pipeline with position tags.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tour_fetch_pipe
  import tsp_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              launch_i,
  input  logic [IDX_W:0]    n_i,
  output logic              tour_rd_en_o,
  output logic [IDX_W-1:0]  tour_addr_o,
  input  logic [IDX_W-1:0]  tour_rdata_i,
  output logic              coord_rd_en_o,
  output logic [IDX_W-1:0]  coord_addr_o,
  input  logic [CITY_W-1:0] coord_rdata_i,
  output logic [CITY_W-1:0] coord_o,
  output logic              first_o,
  output logic              last_o,
  output logic              valid_o
);

  localparam logic [IDX_W:0] ONE_N = (IDX_W+1)'(1);

  logic             issuing_q;
  logic [IDX_W:0]   pos_q;
  logic [IDX_W:0]   n_q;
  logic             s1_vld_q, s1_first_q, s1_last_q;
  logic             s2_vld_q, s2_first_q, s2_last_q;
  logic             pos_last;

  // n is one bit wider than the address so a full 2^IDX_W tour compares correctly.
  assign pos_last = (pos_q == (n_q - ONE_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issuing_q  <= 1'b0;
      pos_q      <= '0;
      n_q        <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      if (launch_i) begin
        issuing_q <= 1'b1;
        pos_q     <= '0;
        n_q       <= n_i;
      end else if (issuing_q) begin
        pos_q <= pos_q + ONE_N;
        if (pos_last) begin
          issuing_q <= 1'b0;
        end
      end
      s1_vld_q   <= issuing_q;
      s1_first_q <= issuing_q && (pos_q == '0);
      s1_last_q  <= issuing_q && pos_last;
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
    end
  end

  assign tour_rd_en_o  = issuing_q;
  assign tour_addr_o   = issuing_q ? pos_q[IDX_W-1:0] : '0;
  assign coord_rd_en_o = s1_vld_q;
  assign coord_addr_o  = s1_vld_q ? tour_rdata_i : '0;
  assign coord_o       = coord_rdata_i;
  assign first_o       = s2_first_q;
  assign last_o        = s2_last_q;
  assign valid_o       = s2_vld_q;

endmodule

`default_nettype wire

// File: rtl/tour_len_ctrl.sv
//------------------------------------------------------------------------------
// Module : tour_len_ctrl
// Brief  : Closed-tour length sequencer: fetches cities, issues pairs, sums distances.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tour_len_ctrl
  import tsp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    num_cities,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  tour_len,
  output logic              overflow,
  output logic              tour_rd_en,
  output logic [IDX_W-1:0]  tour_addr,
  input  logic [IDX_W-1:0]  tour_rdata,
  output logic              coord_rd_en,
  output logic [IDX_W-1:0]  coord_addr,
  input  logic [CITY_W-1:0] coord_rdata,
  output logic              dist_inp_valid,
  output logic [CITY_W-1:0] dist_citya,
  output logic [CITY_W-1:0] dist_cityb,
  input  logic              dist_out_valid,
  input  logic [DIST_W-1:0] dist_out
);

  localparam int SUM_W = ((ACC_W > DIST_W) ? ACC_W : DIST_W) + 1;
  localparam logic [IDX_W:0] ONE_N = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] TWO_N = (IDX_W+1)'(2);

  tl_state_e         state_q, state_d;
  logic [IDX_W:0]    n_q, n_d;
  logic [IDX_W:0]    res_cnt_q, res_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CITY_W-1:0] first_q, first_d;
  logic [CITY_W-1:0] prev_q, prev_d;
  logic [CITY_W-1:0] citya_q, citya_d;
  logic [CITY_W-1:0] cityb_q, cityb_d;
  logic              pair_vld_q, pair_vld_d;
  logic              close_sent_q, close_sent_d;

  logic              launch;
  logic              accept_res;
  logic [SUM_W-1:0]  sum;
  logic [CITY_W-1:0] fp_coord;
  logic              fp_first, fp_last, fp_valid;

  tour_fetch_pipe #(
    .IDX_W (IDX_W)
  ) u_fetch (
    .clk           (clk),
    .rst_n         (rst_n),
    .launch_i      (launch),
    .n_i           (num_cities),
    .tour_rd_en_o  (tour_rd_en),
    .tour_addr_o   (tour_addr),
    .tour_rdata_i  (tour_rdata),
    .coord_rd_en_o (coord_rd_en),
    .coord_addr_o  (coord_addr),
    .coord_rdata_i (coord_rdata),
    .coord_o       (fp_coord),
    .first_o       (fp_first),
    .last_o        (fp_last),
    .valid_o       (fp_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      res_cnt_q    <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      first_q      <= '0;
      prev_q       <= '0;
      citya_q      <= '0;
      cityb_q      <= '0;
      pair_vld_q   <= 1'b0;
      close_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      res_cnt_q    <= res_cnt_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      first_q      <= first_d;
      prev_q       <= prev_d;
      citya_q      <= citya_d;
      cityb_q      <= cityb_d;
      pair_vld_q   <= pair_vld_d;
      close_sent_q <= close_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    res_cnt_d    = res_cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    first_d      = first_q;
    prev_d       = prev_q;
    citya_d      = citya_q;
    cityb_d      = cityb_q;
    pair_vld_d   = 1'b0;
    close_sent_d = close_sent_q;
    launch       = 1'b0;

    // Results are counted whenever the datapath is ours, independent of its latency.
    accept_res = dist_out_valid &&
                 ((state_q == S_FETCH) || (state_q == S_CLOSE) || (state_q == S_DRAIN));
    sum = SUM_W'(acc_q) + SUM_W'(dist_out);
    if (accept_res) begin
      res_cnt_d = res_cnt_q + ONE_N;
      if (|sum[SUM_W-1:ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d          = num_cities;
          acc_d        = '0;
          ovf_d        = 1'b0;
          res_cnt_d    = '0;
          close_sent_d = 1'b0;
          if (num_cities >= TWO_N) begin
            launch  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (fp_valid) begin
          prev_d = fp_coord;
          if (fp_first) begin
            first_d = fp_coord;
          end else begin
            pair_vld_d = 1'b1;
            citya_d    = prev_q;
            cityb_d    = fp_coord;
          end
          if (fp_last) begin
            state_d = S_CLOSE;
          end
        end
      end
      S_CLOSE: begin
        // Stay one extra cycle so the wrap-around pair is on the bus while still in CLOSE.
        if (!close_sent_q) begin
          pair_vld_d   = 1'b1;
          citya_d      = prev_q;
          cityb_d      = first_q;
          close_sent_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_cnt_d == n_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign tour_len       = acc_q;
  assign overflow       = ovf_q;
  assign dist_inp_valid = pair_vld_q;
  assign dist_citya     = citya_q;
  assign dist_cityb     = cityb_q;

endmodule

`default_nettype wire

// File: tb/tb_tour_len_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_tour_len_ctrl
// Brief  : Directed bench for tour_len_ctrl with RAM and distance-unit models.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tour_len_ctrl;
  import tsp_pkg::*;

  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [IDX_W:0]    num_cities = '0;
  logic              busy, done, overflow;
  logic [31:0]       tour_len;
  logic              tour_rd_en, coord_rd_en, dist_inp_valid;
  logic [IDX_W-1:0]  tour_addr, coord_addr;
  logic [IDX_W-1:0]  tour_rdata = '0;
  logic [63:0]       coord_rdata = '0;
  logic [63:0]       dist_citya, dist_cityb;
  logic              dist_out_valid;
  logic [31:0]       dist_out;

  logic              start_s = 1'b0;
  logic [IDX_W:0]    n_s = '0;
  logic              busy_s, done_s, ovf_s;
  logic [7:0]        tour_len_s;
  logic              tour_rd_en_s, coord_rd_en_s, dist_inp_valid_s;
  logic [IDX_W-1:0]  tour_addr_s, coord_addr_s;
  logic [IDX_W-1:0]  tour_rdata_s = '0;
  logic [63:0]       coord_rdata_s = '0;
  logic [63:0]       citya_s, cityb_s;
  logic              dv_s = 1'b0;

  tour_len_ctrl #(.IDX_W(IDX_W), .ACC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cities(num_cities),
    .busy(busy), .done(done), .tour_len(tour_len), .overflow(overflow),
    .tour_rd_en(tour_rd_en), .tour_addr(tour_addr), .tour_rdata(tour_rdata),
    .coord_rd_en(coord_rd_en), .coord_addr(coord_addr), .coord_rdata(coord_rdata),
    .dist_inp_valid(dist_inp_valid), .dist_citya(dist_citya), .dist_cityb(dist_cityb),
    .dist_out_valid(dist_out_valid), .dist_out(dist_out)
  );

  tour_len_ctrl #(.IDX_W(IDX_W), .ACC_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .num_cities(n_s),
    .busy(busy_s), .done(done_s), .tour_len(tour_len_s), .overflow(ovf_s),
    .tour_rd_en(tour_rd_en_s), .tour_addr(tour_addr_s), .tour_rdata(tour_rdata_s),
    .coord_rd_en(coord_rd_en_s), .coord_addr(coord_addr_s), .coord_rdata(coord_rdata_s),
    .dist_inp_valid(dist_inp_valid_s), .dist_citya(citya_s), .dist_cityb(cityb_s),
    .dist_out_valid(dv_s), .dist_out(32'd100)
  );

  // Memory models: registered reads, data one cycle after the strobe.
  logic [IDX_W-1:0] tour_mem [64];
  logic [63:0]      coord_mem [64];
  always @(posedge clk) begin
    if (tour_rd_en)  tour_rdata  <= tour_mem[tour_addr];
    if (coord_rd_en) coord_rdata <= coord_mem[coord_addr];
    if (tour_rd_en_s)  tour_rdata_s  <= tour_addr_s;
    if (coord_rd_en_s) coord_rdata_s <= {58'd0, coord_addr_s};
    dv_s <= dist_inp_valid_s;
  end

  function automatic logic [31:0] edist(input logic [63:0] a, input logic [63:0] b);
    int dx, dy, v, r;
    dx = int'(city_x(a)) - int'(city_x(b));
    dy = int'(city_y(a)) - int'(city_y(b));
    v  = dx * dx + dy * dy;
    r  = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Ideal Euclidean distance unit, latency 7, not affected by the DUT reset.
  logic [6:0]  dv = '0;
  logic [31:0] dd [7];
  always @(posedge clk) begin
    dv    <= {dv[5:0], dist_inp_valid};
    dd[0] <= edist(dist_citya, dist_cityb);
    for (int k = 1; k < 7; k++) dd[k] <= dd[k-1];
  end
  assign dist_out_valid = dv[6];
  assign dist_out       = dd[6];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          pair_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, first_rd_cyc = 0;
  int          done_s_cnt = 0;
  int          pc [64];
  logic [63:0] pa [64];
  logic [63:0] pb [64];
  always @(negedge clk) begin
    if (dist_inp_valid) begin
      pa[pair_cnt] <= dist_citya;
      pb[pair_cnt] <= dist_cityb;
      pc[pair_cnt] <= cyc;
      pair_cnt     <= pair_cnt + 1;
    end
    if (tour_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (tour_addr == '0) first_rd_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (done_s) done_s_cnt <= done_s_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [IDX_W:0] n, output int s);
    start      = 1'b1;
    num_cities = n;
    s          = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    check_eq("done_seen", 64'(done_cnt - base), 64'd1);
  endtask

  task automatic load_square();
    coord_mem[0] = pack_city(32'd0, 32'd0);
    coord_mem[1] = pack_city(32'd3, 32'd0);
    coord_mem[2] = pack_city(32'd3, 32'd4);
    coord_mem[3] = pack_city(32'd0, 32'd4);
    for (int i = 0; i < 4; i++) tour_mem[i] = IDX_W'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, bp, bd, br, k;
    for (int i = 0; i < 64; i++) begin
      tour_mem[i]  = '0;
      coord_mem[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_len", 64'(tour_len), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    check_eq("rst_rd_en", 64'(tour_rd_en), 64'd0);
    check_eq("rst_pair_vld", 64'(dist_inp_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Square tour, n=4
    load_square();
    bp = pair_cnt; bd = done_cnt;
    run_start(7'd4, s);
    check_eq("sq_busy", 64'(busy), 64'd1);
    wait_done(bd, 60);
    check_eq("sq_first_rd", 64'(first_rd_cyc), 64'(s + 1));
    check_eq("sq_pairs", 64'(pair_cnt - bp), 64'd4);
    check_eq("sq_pair0_cyc", 64'(pc[bp]), 64'(s + 5));
    check_eq("sq_pair3_cyc", 64'(pc[bp+3]), 64'(s + 8));
    check_eq("sq_pair0_a", pa[bp], pack_city(32'd0, 32'd0));
    check_eq("sq_pair0_b", pb[bp], pack_city(32'd3, 32'd0));
    check_eq("sq_close_a", pa[bp+3], pack_city(32'd0, 32'd4));
    check_eq("sq_close_b", pb[bp+3], pack_city(32'd0, 32'd0));
    check_eq("sq_len", 64'(tour_len), 64'd14);
    check_eq("sq_ovf", 64'(overflow), 64'd0);
    check_eq("sq_busy_after", 64'(busy), 64'd0);

    // Two cities
    coord_mem[10] = pack_city(32'd0, 32'd0);
    coord_mem[11] = pack_city(32'd6, 32'd8);
    tour_mem[0] = 6'd10; tour_mem[1] = 6'd11;
    bp = pair_cnt; bd = done_cnt;
    run_start(7'd2, s);
    wait_done(bd, 60);
    check_eq("n2_pairs", 64'(pair_cnt - bp), 64'd2);
    check_eq("n2_p0a", pa[bp], coord_mem[10]);
    check_eq("n2_p0b", pb[bp], coord_mem[11]);
    check_eq("n2_p1a", pa[bp+1], coord_mem[11]);
    check_eq("n2_p1b", pb[bp+1], coord_mem[10]);
    check_eq("n2_len", 64'(tour_len), 64'd20);

    // Degenerate tours
    for (int nn = 1; nn >= 0; nn--) begin
      bp = pair_cnt; bd = done_cnt; br = rd_cnt;
      run_start(7'(nn), s);
      wait_done(bd, 10);
      check_eq("small_done_cyc", 64'(done_cyc), 64'(s + 1));
      check_eq("small_len", 64'(tour_len), 64'd0);
      check_eq("small_reads", 64'(rd_cnt - br), 64'd0);
      check_eq("small_pairs", 64'(pair_cnt - bp), 64'd0);
    end

    // Start pulsed while busy is ignored
    load_square();
    bp = pair_cnt; bd = done_cnt;
    run_start(7'd4, s);
    repeat (3) tick();
    start = 1'b1; num_cities = 7'd2;
    tick();
    start = 1'b0;
    wait_done(bd, 60);
    repeat (20) tick();
    check_eq("busy_start_dones", 64'(done_cnt - bd), 64'd1);
    check_eq("busy_start_len", 64'(tour_len), 64'd14);
    check_eq("busy_start_pairs", 64'(pair_cnt - bp), 64'd4);

    // Reset mid-run, late results must be dropped
    run_start(7'd4, s);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_rd_en", 64'(tour_rd_en), 64'd0);
    check_eq("mid_rst_pair_vld", 64'(dist_inp_valid), 64'd0);
    check_eq("mid_rst_citya", dist_citya, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    bd = done_cnt;
    repeat (20) tick();
    check_eq("post_rst_dones", 64'(done_cnt - bd), 64'd0);
    check_eq("post_rst_len", 64'(tour_len), 64'd0);
    bp = pair_cnt; bd = done_cnt;
    run_start(7'd4, s);
    wait_done(bd, 60);
    check_eq("fresh_len", 64'(tour_len), 64'd14);
    check_eq("fresh_pairs", 64'(pair_cnt - bp), 64'd4);

    // Saturation on the 8-bit accumulator instance
    bd = done_s_cnt;
    start_s = 1'b1; n_s = 7'd3;
    tick();
    start_s = 1'b0;
    k = 0;
    while (done_s_cnt == bd && k < 60) begin
      tick();
      k++;
    end
    check_eq("sat_done_seen", 64'(done_s_cnt - bd), 64'd1);
    check_eq("sat_len", 64'(tour_len_s), 64'd255);
    check_eq("sat_ovf", 64'(ovf_s), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
